// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop input synchroniser.
// Samples the start bit at its midpoint and every data/stop bit at its
// midpoint after that. Emits a one-cycle data_valid strobe for a good
// frame and a one-cycle frame_error strobe when the stop bit reads low.
// After a framing error the receiver waits for the line to return high,
// so a held-low (break) line is not decoded as repeated 0x00 frames.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } state_t;

    // Last count value of a full bit period and of a half bit period.
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    logic       rx_ff1_q;
    logic       rx_ff2_q;
    state_t     state_q;
    state_t     state_d;
    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;
    logic [2:0] bit_idx_q;
    logic [2:0] bit_idx_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] data_out_q;
    logic [7:0] data_out_d;
    logic       data_valid_q;
    logic       data_valid_d;
    logic       frame_error_q;
    logic       frame_error_d;
    logic       busy_q;
    logic       busy_d;
    logic       stop_sample_s;

    // The stop bit is judged at its midpoint.
    assign stop_sample_s = (state_q == ST_STOP) && (baud_cnt_q == FULL_LAST);

    // Two-flop synchroniser for the asynchronous rx pin, idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ff1_q <= 1'b1;
            rx_ff2_q <= 1'b1;
        end else begin
            rx_ff1_q <= rx;
            rx_ff2_q <= rx_ff1_q;
        end
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            baud_cnt_q    <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state logic: counter clears on every state change.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = 16'd0;
                bit_idx_d  = 3'd0;
                if (!rx_ff2_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    // A line that is high again mid-start-bit was a glitch.
                    if (!rx_ff2_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == FULL_LAST) begin
                    baud_cnt_d         = 16'd0;
                    shift_d[bit_idx_q] = rx_ff2_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_cnt_q == FULL_LAST) begin
                    baud_cnt_d = 16'd0;
                    // Re-arm at the stop midpoint so back-to-back frames are caught.
                    if (rx_ff2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK_WAIT;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK_WAIT: begin
                baud_cnt_d = 16'd0;
                if (rx_ff2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK_WAIT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = 16'd0;
                bit_idx_d  = 3'd0;
            end
        endcase
    end

    // Output logic: strobes are generated from the stop-bit verdict only.
    always_comb begin
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        if (stop_sample_s) begin
            if (rx_ff2_q) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                frame_error_d = 1'b1;
            end
        end else begin
            data_valid_d  = 1'b0;
            frame_error_d = 1'b0;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit. Stimulus
// pushes the expected strobe (kind, data_out value, spacing to the
// previous good frame) before sending; a monitor pops on each strobe.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   last_valid_cyc = 0;
    bit   prev_dv = 1'b0;
    bit   prev_fe = 1'b0;
    bit   busy_seen;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [7:0] d, input int gap);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic bit_time(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        bit_time(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_time(d[i], CPB);
        bit_time(stop_bit, CPB);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: compare every strobe against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (data_valid && frame_error) check("strobe_exclusive", {frame_error, data_valid}, 2'b01);
        if (data_valid && prev_dv) check("valid_width", {prev_dv, data_valid}, 2'b01);
        if (frame_error && prev_fe) check("ferr_width", {prev_fe, frame_error}, 2'b01);
        if (data_valid || frame_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {frame_error, data_valid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {frame_error, data_valid}, e.is_err ? 2'b10 : 2'b01);
                check("data_out", data_out, e.data);
                if (data_valid) begin
                    if (e.gap >= 0) check("valid_gap", cycle - last_valid_cyc, e.gap);
                    last_valid_cyc = cycle;
                end
            end
        end
        prev_dv = data_valid;
        prev_fe = frame_error;
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Idle line for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_data_out", data_out, 8'h00);
            check("idle_valid", data_valid, 1'b0);
            check("idle_ferr", frame_error, 1'b0);
            check("idle_busy", busy, 1'b0);
        end

        // Good frame 0xA5
        push_exp(1'b0, 8'hA5, -1);
        send_frame(8'hA5, 1'b1);
        bit_time(1'b1, 10);
        drain();
        check("a5_busy_idle", busy, 1'b0);
        check("a5_data_held", data_out, 8'hA5);

        // Short glitch: 5 low cycles is less than half a bit
        busy_seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        check("glitch_busy_rose", busy_seen, 1'b1);
        check("glitch_busy_fell", busy, 1'b0);
        check("glitch_data_held", data_out, 8'hA5);

        // Bad stop bit, break held low, then recovery with 0x7E
        push_exp(1'b1, 8'hA5, -1);
        send_frame(8'h3C, 1'b0);
        bit_time(1'b0, 40);
        check("break_busy", busy, 1'b1);
        check("break_data_held", data_out, 8'hA5);
        bit_time(1'b1, 20);
        check("break_released", busy, 1'b0);
        push_exp(1'b0, 8'h7E, -1);
        send_frame(8'h7E, 1'b1);
        bit_time(1'b1, 10);
        drain();

        // Back-to-back frames: valids exactly one frame (160 clk) apart
        push_exp(1'b0, 8'h00, -1);
        push_exp(1'b0, 8'hFF, 10 * CPB);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        bit_time(1'b1, 10);
        drain();

        // Reset during data bit 4 aborts the frame
        bit_time(1'b0, CPB + 4 * CPB + 8);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_data_out", data_out, 8'h00);
        bit_time(1'b1, 20);
        push_exp(1'b0, 8'h81, -1);
        send_frame(8'h81, 1'b1);
        bit_time(1'b1, 10);
        drain();
        check("final_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the board UART; the counterpart of the button-triggered transmitter path.
- Deserialises an asynchronous 8N1 serial line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) into bytes.
- Emits a one-cycle valid strobe per good frame and a one-cycle framing-error strobe per bad frame.
- Sits directly behind the rx pin; its outputs feed user logic in the clk domain.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud). Legal range 4..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out has just been updated.
- frame_error  output  1  one-cycle pulse when the stop bit sampled low.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Synchroniser:
  - rx passes through a 2-FF synchroniser (rx_ff1, rx_ff2), both reset to 1.
  - All decisions use rx_ff2.
- Reset values: data_out=0x00, data_valid=0, frame_error=0, busy=0, state=IDLE, bit counter=0, baud counter=0.
- Reset asserted mid-frame: aborts the frame at the next edge; no strobe is generated.
- Counters:
  - Baud counter is 16 bits and counts 0..N-1.
  - N = CLKS_PER_BIT in DATA/STOP; N = CLKS_PER_BIT/2, integer division, in START.
  - Counter clears on every state change.
  - Bit index is 3 bits, 0..7.
- IDLE:
  - busy=0.
  - If rx_ff2==0, go to START and clear the baud counter.
- START (mid-start-bit check):
  - When the counter reaches CLKS_PER_BIT/2-1, sample rx_ff2.
  - Sample 0: go to DATA with bit index 0.
  - Sample 1: false start (glitch). Return to IDLE with no strobe.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1 (mid-bit), shift rx_ff2 into shift-register position [bit index].
  - Bit index 7: go to STOP. Otherwise increment the bit index.
- STOP:
  - When the counter reaches CLKS_PER_BIT-1, sample rx_ff2.
  - Sample 1: data_out <= shift register, data_valid=1 for exactly the next cycle, go to IDLE.
  - Sample 0: frame_error=1 for exactly the next cycle, data_out unchanged, go to BREAK_WAIT.
- BREAK_WAIT:
  - busy=1.
  - Stay until rx_ff2==1, then go to IDLE.
  - This prevents a held-low (break) line from being read as back-to-back 0x00 frames.
- Re-arming: IDLE is re-entered at the stop-bit midpoint, so a start bit immediately following the stop bit (back-to-back frames) is detected.
- Strobe exclusivity: data_valid and frame_error are never high in the same cycle. Both are 0 in every cycle not named above.
- Latency: falling edge on rx to the first START counter cycle is 2 clk (synchroniser). data_valid rises one clk after the stop-bit mid-sample.
- Bit timing: data is sampled at 1.5, 2.5, … bit periods after the start edge (plus the synchroniser delay). This tolerates ±~4% baud mismatch.

Test Plan:
- Reset, then idle line high for 100 cycles -> data_out=0x00, data_valid=0, frame_error=0, busy=0 throughout. Use CLKS_PER_BIT=16 in all tests.
- Send 8N1 frame 0xA5 at 16 clk/bit -> data_valid pulses exactly 1 cycle, data_out=0xA5, frame_error never 1, busy returns to 0.
- Drive rx low for 5 cycles (< half bit = 8), then high -> busy rises then falls, no data_valid, no frame_error, data_out unchanged.
- Send 0x3C with stop bit forced 0, line held low 40 cycles, then high, then send 0x7E -> frame_error pulses once, data_out stays at the prior value, no second strobe during the low hold, then data_valid with data_out=0x7E.
- Send 0x00 then 0xFF back-to-back (stop bit immediately followed by start bit) -> two data_valid pulses 160 cycles apart, data_out=0x00 then 0xFF.
- Assert reset for 1 cycle after data bit 3 of a frame, then send 0x81 -> no strobe for the aborted frame, busy=0 the cycle after reset, then data_valid with data_out=0x81.
